// File: rtl/tile_pkg.sv
// Shared types and constants for the double-buffered tile layer store.
package tile_pkg;

  localparam int TILE_ROWS = 32;
  localparam int TILE_COLS = 32;

  typedef logic [TILE_COLS-1:0] tile_row_t;
  typedef logic [4:0]           tile_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    DONE = 2'd2
  } tile_copy_state_t;

endpackage

// File: rtl/tile_layer_bank.sv
// One tile layer: shadow rows written by software, front rows shown to the
// pixel generator, a one-row-per-cycle copy port and a registered bit read.
module tile_layer_bank
  import tile_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  tile_idx_t wr_idx,
  input  tile_row_t wr_data,
  input  logic      copy_en,
  input  tile_idx_t copy_idx,
  input  tile_idx_t rd_x,
  input  tile_idx_t rd_y,
  output logic      rd_bit
);

  tile_row_t shadow [TILE_ROWS];
  tile_row_t front  [TILE_ROWS];
  tile_row_t copy_row;

  // Row being copied takes a same-cycle software write directly (write-through).
  always_comb begin
    copy_row = shadow[copy_idx];
    if (wr_idx == copy_idx) copy_row = wr_data;
  end

  // Shadow mirrors the PIO export into the addressed row every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TILE_ROWS; i++) shadow[i] <= '0;
    end else begin
      shadow[wr_idx] <= wr_data;
    end
  end

  // Front copy is only updated by the copy sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TILE_ROWS; i++) front[i] <= '0;
    end else if (copy_en) begin
      front[copy_idx] <= copy_row;
    end
  end

  // Registered read, bit 0 of a row is the leftmost column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_bit <= 1'b0;
    else        rd_bit <= front[rd_y][rd_x];
  end

endmodule

// File: rtl/tile_layer_buffer.sv
// Double-buffered 32x32 background/food tile store. On vblank_start the shadow
// rows are copied into the displayed rows, one row per cycle, then
// refresh_image is raised. Build option: TILE_FOOD_LAYER_EN adds the food layer;
// without it food_bit is 0 and the food PIO inputs are ignored.
module tile_layer_buffer
  import tile_pkg::*;
(
  input  logic      clk_clk,
  input  logic      reset_reset_n,
  input  tile_row_t background_data,
  input  tile_idx_t background_wr,
  input  tile_row_t food_layer_data,
  input  tile_idx_t food_layer_wr,
  input  logic      vblank_start,
  input  tile_idx_t rd_x,
  input  tile_idx_t rd_y,
  output logic      bg_bit,
  output logic      food_bit,
  output logic      refresh_image,
  output logic      copy_busy
);

  localparam tile_idx_t LAST_ROW = tile_idx_t'(TILE_ROWS - 1);

  tile_copy_state_t state, state_nxt;
  tile_idx_t        row, row_nxt;
  logic             refresh_nxt;
  logic             copy_en;

  // Copy FSM state, row counter and refresh flag.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state         <= IDLE;
      row           <= '0;
      refresh_image <= 1'b0;
    end else begin
      state         <= state_nxt;
      row           <= row_nxt;
      refresh_image <= refresh_nxt;
    end
  end

  // Next-state logic; exit from COPY is decided on the last row, never on wrap.
  always_comb begin
    state_nxt   = state;
    row_nxt     = row;
    refresh_nxt = refresh_image;
    copy_en     = 1'b0;
    case (state)
      IDLE: begin
        if (vblank_start) begin
          state_nxt   = COPY;
          row_nxt     = '0;
          refresh_nxt = 1'b0;
        end
      end
      COPY: begin
        copy_en = 1'b1;
        row_nxt = row + 5'd1;
        if (row == LAST_ROW) begin
          state_nxt   = DONE;
          row_nxt     = '0;
          refresh_nxt = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        row_nxt   = '0;
      end
    endcase
  end

  assign copy_busy = (state == COPY);

  tile_layer_bank u_bg_bank (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .wr_idx   (background_wr),
    .wr_data  (background_data),
    .copy_en  (copy_en),
    .copy_idx (row),
    .rd_x     (rd_x),
    .rd_y     (rd_y),
    .rd_bit   (bg_bit)
  );

`ifdef TILE_FOOD_LAYER_EN
  tile_layer_bank u_food_bank (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .wr_idx   (food_layer_wr),
    .wr_data  (food_layer_data),
    .copy_en  (copy_en),
    .copy_idx (row),
    .rd_x     (rd_x),
    .rd_y     (rd_y),
    .rd_bit   (food_bit)
  );
`else
  logic unused_food;
  assign unused_food = ^{food_layer_data, food_layer_wr};
  assign food_bit    = 1'b0;
`endif

endmodule

// File: tb/tb_tile_layer_buffer.sv
// Testbench for tile_layer_buffer: scoreboard of expected read bits plus
// copy-sequence timing checks, against a bench-side model of the layers.
module tb_tile_layer_buffer;
  import tile_pkg::*;

  logic      clk;
  logic      reset_reset_n;
  tile_row_t background_data;
  tile_idx_t background_wr;
  tile_row_t food_layer_data;
  tile_idx_t food_layer_wr;
  logic      vblank_start;
  tile_idx_t rd_x;
  tile_idx_t rd_y;
  logic      bg_bit;
  logic      food_bit;
  logic      refresh_image;
  logic      copy_busy;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef TILE_FOOD_LAYER_EN
  localparam bit FOOD_ON = 1'b1;
`else
  localparam bit FOOD_ON = 1'b0;
`endif

  tile_row_t m_shadow_bg   [32];
  tile_row_t m_front_bg    [32];
  tile_row_t m_shadow_food [32];
  tile_row_t m_front_food  [32];

  typedef struct packed {
    logic      bg;
    logic      food;
    tile_idx_t x;
    tile_idx_t y;
  } rd_exp_t;

  rd_exp_t sb[$];

  tile_layer_buffer dut (
    .clk_clk         (clk),
    .reset_reset_n   (reset_reset_n),
    .background_data (background_data),
    .background_wr   (background_wr),
    .food_layer_data (food_layer_data),
    .food_layer_wr   (food_layer_wr),
    .vblank_start    (vblank_start),
    .rd_x            (rd_x),
    .rd_y            (rd_y),
    .bg_bit          (bg_bit),
    .food_bit        (food_bit),
    .refresh_image   (refresh_image),
    .copy_busy       (copy_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; the shadow model takes the inputs sampled at this edge.
  task automatic tick();
    if (reset_reset_n) begin
      m_shadow_bg[background_wr]   = background_data;
      m_shadow_food[food_layer_wr] = food_layer_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin
      m_shadow_bg[i]   = '0;
      m_front_bg[i]    = '0;
      m_shadow_food[i] = '0;
      m_front_food[i]  = '0;
    end
  endtask

  task automatic read_px(input tile_idx_t x, input tile_idx_t y);
    rd_exp_t e;
    rd_exp_t o;
    rd_x   = x;
    rd_y   = y;
    e.x    = x;
    e.y    = y;
    e.bg   = m_front_bg[y][x];
    e.food = FOOD_ON ? m_front_food[y][x] : 1'b0;
    sb.push_back(e);
    tick();
    o = sb.pop_front();
    chk($sformatf("bg(%0d,%0d)", o.x, o.y), {31'b0, bg_bit}, {31'b0, o.bg});
    chk($sformatf("food(%0d,%0d)", o.x, o.y), {31'b0, food_bit}, {31'b0, o.food});
  endtask

  // One vblank-triggered copy; optional background write at copy cycle mid_cyc
  // and optional extra vblank pulse at copy cycle extra_vb (-1 disables either).
  task automatic run_copy(input int mid_cyc, input tile_idx_t mid_idx,
                          input tile_row_t mid_data, input int extra_vb);
    int busy_cnt;
    int ref_cnt;
    busy_cnt = 0;
    ref_cnt  = 0;
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k == mid_cyc) begin
        background_wr   = mid_idx;
        background_data = mid_data;
      end
      if (k == extra_vb) vblank_start = 1'b1;
      if (copy_busy)     busy_cnt++;
      if (refresh_image) ref_cnt++;
      tick();
      vblank_start    = 1'b0;
      m_front_bg[k]   = m_shadow_bg[k];
      m_front_food[k] = m_shadow_food[k];
    end
    chk("busy_len", busy_cnt, 32);
    chk("refresh_in_copy", ref_cnt, 0);
    chk("busy_at_done", {31'b0, copy_busy}, 32'd0);
    chk("refresh_at_done", {31'b0, refresh_image}, 32'd1);
    tick();
    chk("refresh_hold", {31'b0, refresh_image}, 32'd1);
    chk("busy_idle", {31'b0, copy_busy}, 32'd0);
  endtask

  initial begin
    clear_model();
    reset_reset_n   = 1'b0;
    background_data = '0;
    background_wr   = '0;
    food_layer_data = '0;
    food_layer_wr   = '0;
    vblank_start    = 1'b0;
    rd_x            = '0;
    rd_y            = '0;
    tick();
    tick();
    reset_reset_n = 1'b1;
    tick();

    // Reset state
    chk("refresh_reset", {31'b0, refresh_image}, 32'd0);
    chk("busy_reset", {31'b0, copy_busy}, 32'd0);
    read_px(5'd3, 5'd7);

    // Shadow write is invisible until a copy
    background_wr = 5'd7;
    tick();
    background_data = 32'h0000_0008;
    tick();
    tick();
    read_px(5'd3, 5'd7);
    run_copy(-1, 5'd0, 32'h0, -1);
    read_px(5'd3, 5'd7);
    read_px(5'd2, 5'd7);
    read_px(5'd4, 5'd7);
    read_px(5'd3, 5'd6);

    // Second vblank mid-copy neither extends nor queues a copy
    run_copy(-1, 5'd0, 32'h0, 10);
    tick();
    chk("no_queued_copy", {31'b0, copy_busy}, 32'd0);
    chk("refresh_still_set", {31'b0, refresh_image}, 32'd1);

    // Write to a pending row during copy is picked up
    run_copy(5, 5'd31, 32'hFFFF_FFFF, -1);
    read_px(5'd0, 5'd31);
    read_px(5'd31, 5'd31);
    read_px(5'd3, 5'd7);

    // Write to an already copied row waits for the next copy
    run_copy(5, 5'd0, 32'h0000_00F0, -1);
    read_px(5'd4, 5'd0);
    run_copy(-1, 5'd0, 32'h0, -1);
    read_px(5'd4, 5'd0);
    read_px(5'd3, 5'd0);

    // Food layer (expected 0 when the layer is not built)
    food_layer_wr = 5'd2;
    tick();
    food_layer_data = 32'hFFFF_FFFF;
    tick();
    run_copy(-1, 5'd0, 32'h0, -1);
    read_px(5'd5, 5'd2);
    read_px(5'd0, 5'd2);
    read_px(5'd3, 5'd7);

    // Asynchronous reset in the middle of a copy
    rd_x = 5'd3;
    rd_y = 5'd7;
    tick();
    chk("bg_pre_reset", {31'b0, bg_bit}, {31'b0, m_front_bg[7][3]});
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    repeat (16) tick();
    chk("busy_mid_copy", {31'b0, copy_busy}, 32'd1);
    reset_reset_n = 1'b0;
    #1;
    chk("bg_async_reset", {31'b0, bg_bit}, 32'd0);
    chk("food_async_reset", {31'b0, food_bit}, 32'd0);
    chk("refresh_async_reset", {31'b0, refresh_image}, 32'd0);
    chk("busy_async_reset", {31'b0, copy_busy}, 32'd0);
    clear_model();
    background_data = '0;
    food_layer_data = '0;
    tick();
    tick();
    reset_reset_n = 1'b1;
    begin
      int busy_seen;
      busy_seen = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (copy_busy || refresh_image) busy_seen++;
      end
      chk("idle_after_reset", busy_seen, 0);
    end
    read_px(5'd3, 5'd7);
    read_px(5'd0, 5'd31);
    read_px(5'd5, 5'd2);
    read_px(5'd4, 5'd0);

    // Normal operation after reset
    background_wr = 5'd12;
    tick();
    background_data = 32'h8000_0001;
    tick();
    run_copy(-1, 5'd0, 32'h0, -1);
    read_px(5'd31, 5'd12);
    read_px(5'd0, 5'd12);
    read_px(5'd1, 5'd12);
    chk("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
